// File: rtl/frame_op_sequencer.sv
// Frame-level command sequencer: latches one op per frame, then walks vblank, hblank and active pixels.
// Optional FRAME_LOOP_EN: when defined, DONE restarts the frame directly with the same op (only abort/Reset stop it).
module frame_op_sequencer #(
    parameter int IM_WIDTH    = 768,
    parameter int IM_HEIGHT   = 512,
    parameter int PIX_PER_CYC = 3,
    parameter int VSYNC_DELAY = 100,
    parameter int HSYNC_DELAY = 160,
    parameter int ADDR_W      = 19
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cmd_sign,
    input  logic [7:0]        cmd_value,
    input  logic              abort,
    input  logic              pix_stall,
    output logic              Vsync,
    output logic              Hsync,
    output logic              pix_valid,
    output logic [9:0]        row,
    output logic [10:0]       col,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [1:0]        op_sel,
    output logic              op_sign,
    output logic [7:0]        op_value,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_HSYNC,
        S_DATA,
        S_DONE
    } state_t;

    localparam int CNT_MAX = (VSYNC_DELAY > HSYNC_DELAY) ? VSYNC_DELAY : HSYNC_DELAY;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VSYNC_DELAY - 1);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(HSYNC_DELAY - 1);
    localparam logic [10:0]      COL_LAST = 11'(IM_WIDTH - PIX_PER_CYC);
    localparam logic [9:0]       ROW_LAST = 10'(IM_HEIGHT - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [9:0]        row_reg;
    logic [10:0]       col_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        op_sel_reg;
    logic              op_sign_reg;
    logic [7:0]        op_value_reg;
    logic [7:0]        frame_cnt_reg;

    logic accept;
    logic advance;
    logic line_end;

    assign accept   = cmd_valid & cmd_ready;
    assign advance  = (state_reg == S_DATA) & ~pix_stall;
    assign line_end = advance & (col_reg == COL_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_VSYNC;
            S_VSYNC: begin
                if (abort)                 state_next = S_IDLE;
                else if (cnt_reg == VS_LAST) state_next = S_HSYNC;
            end
            S_HSYNC: begin
                if (abort)                 state_next = S_IDLE;
                else if (cnt_reg == HS_LAST) state_next = S_DATA;
            end
            S_DATA: begin
                if (abort)         state_next = S_IDLE;
                else if (line_end) state_next = (row_reg == ROW_LAST) ? S_DONE : S_HSYNC;
            end
            S_DONE: begin
                // An abort landing on the DONE cycle never cancels the completed frame.
`ifdef FRAME_LOOP_EN
                state_next = abort ? S_IDLE : S_VSYNC;
`else
                state_next = S_IDLE;
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cnt_reg       <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            addr_reg      <= '0;
            op_sel_reg    <= '0;
            op_sign_reg   <= 1'b0;
            op_value_reg  <= '0;
            frame_cnt_reg <= '0;
        end else begin
            if (accept) begin
                op_sel_reg   <= cmd_op;
                op_sign_reg  <= cmd_sign;
                op_value_reg <= cmd_value;
            end

            // Blanking counter runs only while a blanking state persists; any transition clears it.
            if (((state_reg == S_VSYNC) || (state_reg == S_HSYNC)) && (state_next == state_reg))
                cnt_reg <= cnt_reg + 1'b1;
            else
                cnt_reg <= '0;

            if ((state_reg == S_DONE) || (abort && (state_reg != S_IDLE))) begin
                row_reg  <= '0;
                col_reg  <= '0;
                addr_reg <= '0;
            end else if (advance) begin
                addr_reg <= addr_reg + ADDR_W'(PIX_PER_CYC);
                if (line_end) begin
                    col_reg <= '0;
                    row_reg <= row_reg + 10'd1;
                end else begin
                    col_reg <= col_reg + 11'(PIX_PER_CYC);
                end
            end

            if (state_reg == S_DONE)
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
    end

    assign cmd_ready  = (state_reg == S_IDLE) & ~abort;
    assign busy       = (state_reg != S_IDLE);
    assign Vsync      = (state_reg == S_VSYNC);
    assign Hsync      = (state_reg == S_DATA);
    assign pix_valid  = advance;
    assign frame_done = (state_reg == S_DONE);
    assign row        = row_reg;
    assign col        = col_reg;
    assign pix_addr   = addr_reg;
    assign op_sel     = op_sel_reg;
    assign op_sign    = op_sign_reg;
    assign op_value   = op_value_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_frame_op_sequencer.sv
// Directed bench for frame_op_sequencer on a 6x2 frame, 3 pixels/cycle, vblank 4, hblank 2.
module tb_frame_op_sequencer;

    localparam int W  = 6;
    localparam int H  = 2;
    localparam int P  = 3;
    localparam int VD = 4;
    localparam int HD = 2;
    localparam int AW = 19;

    logic          clk;
    logic          Reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic          cmd_sign;
    logic [7:0]    cmd_value;
    logic          abort;
    logic          pix_stall;
    logic          Vsync;
    logic          Hsync;
    logic          pix_valid;
    logic [9:0]    row;
    logic [10:0]   col;
    logic [AW-1:0] pix_addr;
    logic [1:0]    op_sel;
    logic          op_sign;
    logic [7:0]    op_value;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_cnt;

    int checks;
    int failures;
    int exp_frames;

    frame_op_sequencer #(
        .IM_WIDTH(W), .IM_HEIGHT(H), .PIX_PER_CYC(P),
        .VSYNC_DELAY(VD), .HSYNC_DELAY(HD), .ADDR_W(AW)
    ) dut (
        .clk(clk), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sign(cmd_sign), .cmd_value(cmd_value),
        .abort(abort), .pix_stall(pix_stall),
        .Vsync(Vsync), .Hsync(Hsync), .pix_valid(pix_valid),
        .row(row), .col(col), .pix_addr(pix_addr),
        .op_sel(op_sel), .op_sign(op_sign), .op_value(op_value),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%0b exp=1", cmd_ready); end
        checks++; if ({Vsync, Hsync, pix_valid, busy, frame_done} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {Vsync, Hsync, pix_valid, busy, frame_done}); end
        checks++; if (pix_addr !== '0 || row !== '0 || col !== '0) begin failures++; $display("FAIL reset_pos got addr=%0d row=%0d col=%0d exp=0", pix_addr, row, col); end
        checks++; if ({op_sel, op_sign, op_value, frame_cnt} !== 19'b0) begin failures++; $display("FAIL reset_regs got sel=%0d sign=%0b val=%0d cnt=%0d exp=0", op_sel, op_sign, op_value, frame_cnt); end
        tick();
        Reset = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_frame();
        logic [0:14] vs, hs, dn;
        int ea[15], er[15], ec[15];
        vs = 15'b011110000000000;
        hs = 15'b000000011001100;
        dn = 15'b000000000000010;
        ea = '{0,0,0,0,0,0,0,0,3,0,0,6,9,0,0};
        er = '{0,0,0,0,0,0,0,0,0,0,0,1,1,0,0};
        ec = '{0,0,0,0,0,0,0,0,3,0,0,0,3,0,0};
        for (int i = 0; i < 15; i++) begin
            tick();
            cmd_valid = (i == 0); cmd_op = 2'b01; cmd_sign = 1'b1; cmd_value = 8'd100;
            @(negedge clk);
            if (i == 0) begin
                checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL frame_accept_ready got=%0b exp=1", cmd_ready); end
            end
            checks++; if (Vsync !== vs[i]) begin failures++; $display("FAIL frame_vsync c%0d got=%0b exp=%0b", i, Vsync, vs[i]); end
            checks++; if (Hsync !== hs[i] || pix_valid !== hs[i]) begin failures++; $display("FAIL frame_hsync_pv c%0d got=%0b%0b exp=%0b%0b", i, Hsync, pix_valid, hs[i], hs[i]); end
            checks++; if (frame_done !== dn[i]) begin failures++; $display("FAIL frame_done c%0d got=%0b exp=%0b", i, frame_done, dn[i]); end
            checks++; if (busy !== (i >= 1 && i <= 13)) begin failures++; $display("FAIL frame_busy c%0d got=%0b", i, busy); end
            if (hs[i]) begin
                checks++; if (pix_addr !== ea[i] || row !== er[i] || col !== ec[i]) begin failures++; $display("FAIL frame_pos c%0d got addr=%0d row=%0d col=%0d exp %0d/%0d/%0d", i, pix_addr, row, col, ea[i], er[i], ec[i]); end
            end
            if (i >= 1) begin
                checks++; if (op_sel !== 2'b01 || op_sign !== 1'b1 || op_value !== 8'd100) begin failures++; $display("FAIL frame_op c%0d got sel=%0d sign=%0b val=%0d exp 1/1/100", i, op_sel, op_sign, op_value); end
            end
        end
        exp_frames++;
        checks++; if (frame_cnt !== 8'(exp_frames)) begin failures++; $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); end
        checks++; if (cmd_ready !== 1'b1 || pix_addr !== '0 || row !== '0 || col !== '0) begin failures++; $display("FAIL frame_idle got ready=%0b addr=%0d row=%0d col=%0d", cmd_ready, pix_addr, row, col); end
        $display("test_frame done");
    endtask

    task automatic test_stall();
        logic [0:17] st, hs, pv, dn;
        int ea[18];
        st = 18'b000000001110000000;
        hs = 18'b000000011111001100;
        pv = 18'b000000010001001100;
        dn = 18'b000000000000000010;
        ea = '{0,0,0,0,0,0,0,0,3,3,3,3,0,0,6,9,0,0};
        for (int i = 0; i < 18; i++) begin
            tick();
            cmd_valid = (i == 0); cmd_op = 2'b01; cmd_sign = 1'b1; cmd_value = 8'd100;
            pix_stall = st[i];
            @(negedge clk);
            checks++; if (Hsync !== hs[i] || pix_valid !== pv[i]) begin failures++; $display("FAIL stall_hsync_pv c%0d got=%0b%0b exp=%0b%0b", i, Hsync, pix_valid, hs[i], pv[i]); end
            checks++; if (frame_done !== dn[i]) begin failures++; $display("FAIL stall_done c%0d got=%0b exp=%0b", i, frame_done, dn[i]); end
            if (hs[i]) begin
                checks++; if (pix_addr !== ea[i]) begin failures++; $display("FAIL stall_addr c%0d got=%0d exp=%0d", i, pix_addr, ea[i]); end
            end
        end
        pix_stall = 1'b0;
        exp_frames++;
        checks++; if (frame_cnt !== 8'(exp_frames)) begin failures++; $display("FAIL stall_cnt got=%0d exp=%0d", frame_cnt, exp_frames); end
        $display("test_stall done");
    endtask

    task automatic test_abort();
        for (int i = 0; i < 13; i++) begin
            tick();
            cmd_valid = (i == 0) || (i == 11); cmd_op = 2'b01; cmd_sign = 1'b1; cmd_value = 8'd100;
            abort = (i == 9) || (i == 11);
            @(negedge clk);
            checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL abort_no_done c%0d got=%0b exp=0", i, frame_done); end
            if (i == 9) begin
                checks++; if (busy !== 1'b1 || Hsync !== 1'b0 || row !== 10'd1) begin failures++; $display("FAIL abort_pre c%0d got busy=%0b hs=%0b row=%0d exp 1/0/1", i, busy, Hsync, row); end
            end
            if (i == 10) begin
                checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_idle got busy=%0b ready=%0b exp 0/1", busy, cmd_ready); end
                checks++; if (pix_addr !== '0 || row !== '0 || col !== '0) begin failures++; $display("FAIL abort_clear got addr=%0d row=%0d col=%0d exp 0", pix_addr, row, col); end
                checks++; if (frame_cnt !== 8'(exp_frames) || op_value !== 8'd100) begin failures++; $display("FAIL abort_keep got cnt=%0d val=%0d exp %0d/100", frame_cnt, op_value, exp_frames); end
            end
            if (i == 11) begin
                checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL abort_idle_block got=%0b exp=0", cmd_ready); end
            end
            if (i == 12) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle_noaccept got busy=%0b exp=0", busy); end
            end
        end
        abort = 1'b0; cmd_valid = 1'b0;
        $display("test_abort done");
    endtask

    task automatic test_busy_cmd();
        int n;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) begin
                cmd_valid = 1'b1; cmd_op = 2'b01; cmd_sign = 1'b1; cmd_value = 8'd100;
            end else begin
                cmd_valid = (i <= 14); cmd_op = 2'b11; cmd_sign = 1'b0; cmd_value = 8'd7;
            end
            @(negedge clk);
            if (i >= 1 && i <= 13) begin
                checks++; if (cmd_ready !== 1'b0 || op_sel !== 2'b01 || op_value !== 8'd100) begin failures++; $display("FAIL busy_ignore c%0d got ready=%0b sel=%0d val=%0d exp 0/1/100", i, cmd_ready, op_sel, op_value); end
            end
            if (i == 14) begin
                checks++; if (cmd_ready !== 1'b1 || op_sel !== 2'b01) begin failures++; $display("FAIL busy_idle got ready=%0b sel=%0d exp 1/1", cmd_ready, op_sel); end
            end
            if (i == 15) begin
                checks++; if (busy !== 1'b1 || op_sel !== 2'b11 || op_value !== 8'd7 || op_sign !== 1'b0) begin failures++; $display("FAIL busy_accept got busy=%0b sel=%0d val=%0d sign=%0b exp 1/3/7/0", busy, op_sel, op_value, op_sign); end
            end
        end
        exp_frames++;
        n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            tick(); @(negedge clk); n++;
        end
        checks++; if (n >= 40) begin failures++; $display("FAIL busy_second_timeout got no frame_done exp within 40"); end
        exp_frames++;
        tick(); @(negedge clk);
        checks++; if (frame_cnt !== 8'(exp_frames) || busy !== 1'b0) begin failures++; $display("FAIL busy_second_cnt got cnt=%0d busy=%0b exp %0d/0", frame_cnt, busy, exp_frames); end
        $display("test_busy_cmd done");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) begin
            tick();
            cmd_valid = (i == 0); cmd_op = 2'b10; cmd_sign = 1'b1; cmd_value = 8'd55;
            @(negedge clk);
        end
        checks++; if (Hsync !== 1'b1 || pix_addr !== 19'd3) begin failures++; $display("FAIL rstmid_pre got hs=%0b addr=%0d exp 1/3", Hsync, pix_addr); end
        #2;
        Reset = 1'b0;
        #1;
        checks++; if ({Vsync, Hsync, pix_valid, busy, frame_done} !== 5'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid_flags got=%b ready=%0b exp 00000/1", {Vsync, Hsync, pix_valid, busy, frame_done}, cmd_ready); end
        checks++; if (pix_addr !== '0 || row !== '0 || col !== '0 || op_sel !== '0 || op_value !== '0 || frame_cnt !== '0) begin failures++; $display("FAIL rstmid_regs got addr=%0d row=%0d col=%0d sel=%0d val=%0d cnt=%0d exp 0", pix_addr, row, col, op_sel, op_value, frame_cnt); end
        exp_frames = 0;
        tick();
        Reset = 1'b1;
        @(negedge clk);
        $display("test_reset_mid done");
    endtask

    task automatic test_wrap();
        int n;
        for (int f = 0; f < 256; f++) begin
            tick();
            cmd_valid = 1'b1; cmd_op = 2'b00; cmd_sign = 1'b0; cmd_value = 8'd0;
            @(negedge clk);
            n = 0;
            do begin
                tick(); cmd_valid = 1'b0; @(negedge clk); n++;
            end while (frame_done !== 1'b1 && n < 30);
            if (n >= 30) begin
                checks++; failures++;
                $display("FAIL wrap_timeout frame=%0d got no frame_done exp within 30", f);
                return;
            end
            tick(); @(negedge clk);
            exp_frames = (exp_frames + 1) % 256;
            checks++; if (frame_cnt !== 8'(exp_frames)) begin failures++; $display("FAIL wrap_cnt frame=%0d got=%0d exp=%0d", f, frame_cnt, exp_frames); end
        end
        $display("test_wrap done frame_cnt=%0d", frame_cnt);
    endtask

`ifdef FRAME_LOOP_EN
    task automatic test_loop();
        for (int i = 0; i < 42; i++) begin
            tick();
            cmd_valid = (i == 0); cmd_op = 2'b01; cmd_sign = 1'b1; cmd_value = 8'd100;
            abort = (i == 40);
            @(negedge clk);
            if (i >= 1 && i <= 40) begin
                checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL loop_busy c%0d got busy=%0b ready=%0b exp 1/0", i, busy, cmd_ready); end
                checks++; if (Vsync !== (((i - 1) % 13) < 4)) begin failures++; $display("FAIL loop_vsync c%0d got=%0b", i, Vsync); end
                checks++; if (frame_done !== ((i % 13) == 0)) begin failures++; $display("FAIL loop_done c%0d got=%0b", i, frame_done); end
            end
        end
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || frame_cnt !== 8'd3) begin failures++; $display("FAIL loop_abort got busy=%0b cnt=%0d exp 0/3", busy, frame_cnt); end
        $display("test_loop done");
    endtask
`endif

    initial begin
        checks = 0; failures = 0; exp_frames = 0;
        Reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_sign = 1'b0;
        cmd_value = 8'd0; abort = 1'b0; pix_stall = 1'b0;
        test_reset();
`ifdef FRAME_LOOP_EN
        test_loop();
`else
        test_frame();
        test_stall();
        test_abort();
        test_busy_cmd();
        test_reset_mid();
        test_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
